// File: rtl/lut_mode_ctrl.sv
// lut_mode_ctrl: mode-selectable 2-input LUT evaluator with input debouncing and an operand-sweep self-test.
//   CLKIN/RST        clock, synchronous active-high reset
//   a_raw/b_raw      asynchronous operand pins; mode_raw asynchronous mode button
//   test_start       one-cycle pulse that starts the self-test sweep
//   lut_init/mode    active 16-bit table and function code (0 AND, 1 OR, 2 XOR, 3 NAND)
//   y                registered LUT output
//   busy/test_done   sweep in progress / one-cycle completion pulse
//   test_pass        sweep matched the table; test_result captured y per operand index {b,a}
module lut_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int STEP_CYCLES = 4
) (
  input  logic        CLKIN,
  input  logic        RST,
  input  logic        a_raw,
  input  logic        b_raw,
  input  logic        mode_raw,
  input  logic        test_start,
  output logic [15:0] lut_init,
  output logic [1:0]  mode,
  output logic        y,
  output logic        busy,
  output logic        test_done,
  output logic        test_pass,
  output logic [3:0]  test_result
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STEP_CYCLES);
  localparam logic [1:0] IDLE = 2'd0, STEP = 2'd1, DONE = 2'd2;
  logic [2:0] s1_q, s2_q, deb;
  logic mode_prev_q;
  logic [1:0] state_q, state_d, mode_q, mode_d, k_q, k_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [15:0] lut_q, lut_d;
  logic [3:0] res_q, res_d;
  logic y_q, y_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic idle, rise, last, a_eff, b_eff;
  always_ff @(posedge CLKIN) begin
    if (RST) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {mode_raw, b_raw, a_raw};
      s2_q <= s1_q;
    end
  end
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [CW-1:0] cnt_q;
    logic db_q;
    // Counter runs only while the synced pin disagrees with the debounced value.
    always_ff @(posedge CLKIN) begin
      if (RST) begin
        cnt_q <= '0;
        db_q <= 1'b0;
      end else if (s2_q[i] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q <= '0;
        db_q <= s2_q[i];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign deb[i] = db_q;
  end
  always_comb begin
    idle = state_q == IDLE;
    rise = deb[2] & ~mode_prev_q;
    mode_d = (idle && rise) ? mode_q + 2'd1 : mode_q;
    lut_d = mode_d == 2'd0 ? 16'h8888 : mode_d == 2'd1 ? 16'hEEEE : mode_d == 2'd2 ? 16'h6666 : 16'h7777;
    a_eff = state_q == STEP ? k_q[0] : deb[0];
    b_eff = state_q == STEP ? k_q[1] : deb[1];
    y_d = lut_q[{2'b00, b_eff, a_eff}];
    last = state_q == STEP && scnt_q == SW'(STEP_CYCLES - 1);
    state_d = state_q;
    k_d = k_q;
    scnt_d = scnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;
    res_d = res_q;
    if (idle && test_start) begin
      state_d = STEP;
      k_d = 2'd0;
      scnt_d = '0;
      busy_d = 1'b1;
      res_d = 4'd0;
    end else if (state_q == STEP) begin
      scnt_d = scnt_q + 1'b1;
      if (last) begin
        // y now reflects operand k, held since the previous cycle.
        res_d[k_q] = y_q;
        scnt_d = '0;
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = DONE;
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = {y_q, res_q[2:0]} == lut_q[3:0];
        end
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLKIN) begin
    if (RST) begin
      mode_prev_q <= 1'b0;
      state_q <= IDLE;
      mode_q <= 2'd0;
      k_q <= 2'd0;
      scnt_q <= '0;
      lut_q <= 16'h8888;
      res_q <= 4'd0;
      y_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      mode_prev_q <= deb[2];
      state_q <= state_d;
      mode_q <= mode_d;
      k_q <= k_d;
      scnt_q <= scnt_d;
      lut_q <= lut_d;
      res_q <= res_d;
      y_q <= y_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end
  assign lut_init = lut_q;
  assign mode = mode_q;
  assign y = y_q;
  assign busy = busy_q;
  assign test_done = done_q;
  assign test_pass = pass_q;
  assign test_result = res_q;
endmodule

// File: tb/tb_lut_mode_ctrl.sv
// tb_lut_mode_ctrl: directed checks of debounce, mode stepping, LUT output and self-test.
module tb_lut_mode_ctrl;
  logic clk = 1'b0, rst = 1'b1, a_raw = 1'b0, b_raw = 1'b0, mode_raw = 1'b0, test_start = 1'b0;
  logic [15:0] lut_init;
  logic [1:0] mode;
  logic y, busy, test_done, test_pass;
  logic [3:0] test_result;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  lut_mode_ctrl #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(4)) dut (
    .CLKIN(clk), .RST(rst), .a_raw(a_raw), .b_raw(b_raw), .mode_raw(mode_raw),
    .test_start(test_start), .lut_init(lut_init), .mode(mode), .y(y), .busy(busy),
    .test_done(test_done), .test_pass(test_pass), .test_result(test_result)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic press();
    mode_raw = 1'b1;
    repeat (8) tick();
    mode_raw = 1'b0;
    repeat (8) tick();
  endtask
  task automatic start_pulse();
    test_start = 1'b1;
    tick();
    test_start = 1'b0;
  endtask
  initial begin
    int busy_cnt, done_cnt, ymax;
    logic pass_at_done;
    logic [3:0] res_at_done;
    logic [15:0] exp_lut [4];
    logic [1:0] exp_y [4];
    exp_lut = '{16'hEEEE, 16'h6666, 16'h7777, 16'h8888};
    exp_y = '{2'd1, 2'd1, 2'd1, 2'd0};
    repeat (2) tick();
    rst = 1'b0;
    chk("rst mode", 16'(mode), 16'd0);
    chk("rst lut", lut_init, 16'h8888);
    chk("rst y", 16'(y), 16'd0);
    chk("rst busy", 16'(busy), 16'd0);
    chk("rst done", 16'(test_done), 16'd0);
    chk("rst pass", 16'(test_pass), 16'd0);
    chk("rst result", 16'(test_result), 16'd0);
    a_raw = 1'b1;
    b_raw = 1'b1;
    repeat (6) tick();
    chk("and y latency", 16'(y), 16'd0);
    tick();
    chk("and y", 16'(y), 16'd1);
    chk("and lut", lut_init, 16'h8888);
    chk("and mode", 16'(mode), 16'd0);
    a_raw = 1'b0;
    repeat (10) tick();
    chk("a low y", 16'(y), 16'd0);
    a_raw = 1'b1;
    ymax = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) a_raw = 1'b0;
      tick();
      if (y) ymax = 1;
    end
    chk("glitch y", 16'(ymax), 16'd0);
    b_raw = 1'b0;
    a_raw = 1'b1;
    repeat (10) tick();
    chk("a1b0 y", 16'(y), 16'd0);
    for (int p = 0; p < 4; p++) begin
      press();
      chk($sformatf("press%0d mode", p), 16'(mode), 16'((p + 1) % 4));
      chk($sformatf("press%0d lut", p), lut_init, exp_lut[p]);
      chk($sformatf("press%0d y", p), 16'(y), 16'(exp_y[p]));
    end
    press();
    press();
    chk("xor mode", 16'(mode), 16'd2);
    start_pulse();
    busy_cnt = 0;
    done_cnt = 0;
    pass_at_done = 1'b0;
    res_at_done = 4'd0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cnt++;
      if (test_done) begin
        done_cnt++;
        pass_at_done = test_pass;
        res_at_done = test_result;
      end
      tick();
    end
    chk("xor busy cycles", 16'(busy_cnt), 16'd16);
    chk("xor done pulses", 16'(done_cnt), 16'd1);
    chk("xor pass", 16'(pass_at_done), 16'd1);
    chk("xor result", 16'(res_at_done), 16'b0110);
    chk("xor pass hold", 16'(test_pass), 16'd1);
    start_pulse();
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      mode_raw = (i >= 2 && i < 10);
      test_start = (i == 5);
      if (test_done) done_cnt++;
      tick();
    end
    test_start = 1'b0;
    chk("busy press mode", 16'(mode), 16'd2);
    chk("busy press lut", lut_init, 16'h6666);
    chk("double start done", 16'(done_cnt), 16'd1);
    chk("double start result", 16'(test_result), 16'b0110);
    start_pulse();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", 16'(busy), 16'd0);
    chk("abort mode", 16'(mode), 16'd0);
    chk("abort y", 16'(y), 16'd0);
    chk("abort lut", lut_init, 16'h8888);
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (test_done) done_cnt++;
      tick();
    end
    chk("abort no done", 16'(done_cnt), 16'd0);
    start_pulse();
    done_cnt = 0;
    for (int i = 0; i < 40 && done_cnt == 0; i++) begin
      if (test_done) begin
        done_cnt++;
        pass_at_done = test_pass;
        res_at_done = test_result;
      end else begin
        tick();
      end
    end
    chk("fresh done seen", 16'(done_cnt), 16'd1);
    chk("fresh pass", 16'(pass_at_done), 16'd1);
    chk("fresh result", 16'(res_at_done), 16'b1000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
